// File: rtl/pmem_line_responder.sv
// Memory-side responder for the cache pmem line handshake: a line-granular
// backing store answering each read/write with a one-cycle pmem_resp after a fixed latency.
module pmem_line_responder #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned LINE_BITS     = 256,
  parameter int unsigned OFFSET_BITS   = 5,
  parameter int unsigned INDEX_BITS    = 6,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [ADDR_W-1:0]    pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp,
  output logic                 busy,
  output logic                 proto_err
);

  localparam int unsigned DEPTH   = 1 << INDEX_BITS;
  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);
  localparam bit RD_LAT1 = (READ_LATENCY == 32'd1);
  localparam bit WR_LAT1 = (WRITE_LATENCY == 32'd1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_op_q, wr_op_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [LINE_BITS-1:0]  wdata_q, wdata_d;
  logic [LINE_BITS-1:0]  rdata_q, rdata_d;
  logic                  resp_q, resp_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [LINE_BITS-1:0]  store_q [DEPTH];
  logic                  store_we_c;
  logic                  req_c;
  logic [INDEX_BITS-1:0] req_idx_c;
  logic                  unused_addr_c;

  assign req_c         = pmem_read | pmem_write;
  assign req_idx_c     = pmem_address[OFFSET_BITS +: INDEX_BITS];
  assign unused_addr_c = ^pmem_address;

  // Next-state, capture and response decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_op_d    = wr_op_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    store_we_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          wr_op_d = pmem_write;
          idx_d   = req_idx_c;
          wdata_d = pmem_wdata;
          if (pmem_read && pmem_write) err_d = 1'b1;
          if (pmem_write) begin
            cnt_d   = WR_LOAD;
            state_d = WR_LAT1 ? RESP : WAIT;
          end else begin
            cnt_d = RD_LOAD;
            if (RD_LAT1) begin
              state_d = RESP;
              rdata_d = store_q[req_idx_c];
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (!req_c) begin
          // requester gave up: drop the transfer without touching the store
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = RESP;
            if (!wr_op_q) rdata_d = store_q[idx_q];
          end
        end
      end
      RESP: begin
        state_d    = IDLE;
        cnt_d      = '0;
        store_we_c = wr_op_q;
      end
      default: state_d = IDLE;
    endcase
    resp_d = (state_d == RESP);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_op_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_op_q <= wr_op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Backing store survives reset; writes land at the edge closing RESP
  always_ff @(posedge clk) begin
    if (store_we_c) store_q[idx_q] <= wdata_q;
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = resp_q;
  assign busy       = busy_q;
  assign proto_err  = err_q;

endmodule
